// File: rtl/key_event.sv
// Turns a debounced, slow-domain key level into single-cycle press, release,
// long-press and auto-repeat strobes, with power-up phantom-press suppression.
module key_event #(
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic press,
    output logic released,
    output logic long,
    output logic key,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_REL,
        IDLE,
        HELD,
        REPEAT
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             s1;
    logic             s2;
    logic             rdy1;
    logic             rdy2;
    logic             lvl_s;
    logic             press_n;
    logic             released_n;
    logic             long_n;
    logic             key_n;
    logic             held_n;

    assign lvl_s = s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            rdy1     <= 1'b0;
            rdy2     <= 1'b0;
            state    <= WAIT_REL;
            cnt      <= '0;
            press    <= 1'b0;
            released <= 1'b0;
            long     <= 1'b0;
            key      <= 1'b0;
            held     <= 1'b0;
        end else begin
            s1       <= level;
            s2       <= s1;
            // rdy2 rises once s2 carries a sampled level rather than the
            // reset value, so WAIT_REL cannot mistake the flushed zero for
            // a genuine release.
            rdy1     <= 1'b1;
            rdy2     <= rdy1;
            state    <= state_n;
            cnt      <= cnt_n;
            press    <= press_n;
            released <= released_n;
            long     <= long_n;
            key      <= key_n;
            held     <= held_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        press_n    = 1'b0;
        released_n = 1'b0;
        long_n     = 1'b0;
        key_n      = 1'b0;

        case (state)
            WAIT_REL: begin
                cnt_n = '0;
                if (rdy2 && !lvl_s) begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                cnt_n = '0;
                if (lvl_s) begin
                    state_n = HELD;
                    press_n = 1'b1;
                    key_n   = 1'b1;
                end
            end
            HELD: begin
                if (!lvl_s) begin
                    state_n    = IDLE;
                    cnt_n      = '0;
                    released_n = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_n = REPEAT;
                    cnt_n   = '0;
                    long_n  = 1'b1;
                    key_n   = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            REPEAT: begin
                // Release wins over a repeat point landing in the same cycle.
                if (!lvl_s) begin
                    state_n    = IDLE;
                    cnt_n      = '0;
                    released_n = 1'b1;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_n = '0;
                    key_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = WAIT_REL;
                cnt_n   = '0;
            end
        endcase

        held_n = (state_n == HELD) || (state_n == REPEAT);
    end

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: stimulus queues expected strobes with the
// edge they must appear after; a monitor pops and compares each strobe.
module tb_key_event;

    localparam int LC = 8;
    localparam int RC = 4;

    logic clk = 1'b0;
    logic reset;
    logic level;
    logic press;
    logic released;
    logic long;
    logic key;
    logic held;

    key_event #(
        .LONG_CYCLES  (LC),
        .REPEAT_CYCLES(RC),
        .CNT_W        (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .level   (level),
        .press   (press),
        .released(released),
        .long    (long),
        .key     (key),
        .held    (held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int at;
        bit p;
        bit r;
        bit l;
        bit k;
        bit h;
    } ev_t;

    ev_t q[$];
    int  tests = 0;
    int  fails = 0;
    int  n_press = 0;
    int  n_rel = 0;
    bit  held_chk = 1'b0;
    bit  end_req = 1'b0;
    bit  end_done = 1'b0;

    task automatic drive(input logic v, input int n);
        level = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int at, input bit p, input bit r,
                             input bit l, input bit k, input bit h);
        ev_t e;
        e = '{at, p, r, l, k, h};
        q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        ev_t e;
        if (press || released || long || key) begin
            tests++;
            if (press) n_press++;
            if (released) n_rel++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe edge=%0d got p=%b r=%b l=%b k=%b h=%b, required no strobe",
                         cyc, press, released, long, key, held);
            end else begin
                e = q.pop_front();
                if (e.at != cyc || press !== e.p || released !== e.r ||
                    long !== e.l || key !== e.k || held !== e.h) begin
                    fails++;
                    $display("FAIL strobe got edge=%0d p=%b r=%b l=%b k=%b h=%b, required edge=%0d p=%b r=%b l=%b k=%b h=%b",
                             cyc, press, released, long, key, held,
                             e.at, e.p, e.r, e.l, e.k, e.h);
                end
            end
        end
        if (held_chk) begin
            tests++;
            if (held !== 1'b0) begin
                fails++;
                $display("FAIL held_idle edge=%0d got held=%b, required 0", cyc, held);
            end
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            tests++;
            if (q.size() != 0) begin
                fails++;
                $display("FAIL missing_strobes got %0d pending, required 0 (next due edge %0d)",
                         q.size(), q[0].at);
            end
            tests++;
            if (n_press != 16) begin
                fails++;
                $display("FAIL press_count got %0d, required 16", n_press);
            end
            tests++;
            if (n_rel != 15) begin
                fails++;
                $display("FAIL release_count got %0d, required 15", n_rel);
            end
        end
    end

    initial begin
        int e0;
        reset = 1'b1;
        level = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Power-up with the key already high: nothing until it is released.
        held_chk = 1'b1;
        drive(1'b1, 10);
        drive(1'b0, 3);
        held_chk = 1'b0;
        e0 = cyc + 1;
        expect_ev(e0 + 2, 1, 0, 0, 1, 1);
        expect_ev(e0 + 5, 0, 1, 0, 0, 0);
        drive(1'b1, 3);
        drive(1'b0, 6);

        // Short hold: press then release, no long.
        e0 = cyc + 1;
        expect_ev(e0 + 2, 1, 0, 0, 1, 1);
        expect_ev(e0 + 7, 0, 1, 0, 0, 0);
        drive(1'b1, 5);
        drive(1'b0, 8);

        // Long hold with auto-repeat; the repeat due with the release is dropped.
        e0 = cyc + 1;
        expect_ev(e0 + 2,  1, 0, 0, 1, 1);
        expect_ev(e0 + 10, 0, 0, 1, 1, 1);
        expect_ev(e0 + 14, 0, 0, 0, 1, 1);
        expect_ev(e0 + 18, 0, 0, 0, 1, 1);
        expect_ev(e0 + 22, 0, 1, 0, 0, 0);
        drive(1'b1, 20);
        drive(1'b0, 8);

        // Reset mid-hold: outputs drop, no press until a real release.
        e0 = cyc + 1;
        expect_ev(e0 + 2,  1, 0, 0, 1, 1);
        expect_ev(e0 + 10, 0, 0, 1, 1, 1);
        drive(1'b1, 12);
        reset = 1'b1;
        drive(1'b1, 1);
        reset = 1'b0;
        held_chk = 1'b1;
        drive(1'b1, 10);
        drive(1'b0, 3);
        held_chk = 1'b0;
        e0 = cyc + 1;
        expect_ev(e0 + 2, 1, 0, 0, 1, 1);
        expect_ev(e0 + 5, 0, 1, 0, 0, 0);
        drive(1'b1, 3);
        drive(1'b0, 6);

        // Single-cycle glitch: back-to-back press and release.
        e0 = cyc + 1;
        expect_ev(e0 + 2, 1, 0, 0, 1, 1);
        expect_ev(e0 + 3, 0, 1, 0, 0, 0);
        drive(1'b1, 1);
        drive(1'b0, 6);

        // Toggle every two cycles for 40 cycles.
        e0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            expect_ev(e0 + 4 * i + 2, 1, 0, 0, 1, 1);
            expect_ev(e0 + 4 * i + 4, 0, 1, 0, 0, 0);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2);
            drive(1'b0, 2);
        end
        drive(1'b0, 6);

        end_req = 1'b1;
        repeat (3) @(negedge clk);
        if (!end_done) begin
            $display("FAIL end_check got not_run, required run");
            $fatal(1, "end-of-test checks did not execute");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
